id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute stage of the pipelined datapath. Drives the register file read addresses, takes the two read values, optionally bypasses the same-cycle writeback value, and captures operands and control into the ID/EX pipeline register. Detects load-use hazards, inserts one bubble and stalls IF/ID. Also honours flush from branch resolution and back-pressure from a multi-cycle EX unit.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register index width
- CTRL_W, 12, width of the opaque EX/MEM/WB control bundle

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt, id_rd  in  AW  source and destination indices from the instruction
- id_uses_rt  in  1  instruction reads rt as a source
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes a register
- id_imm  in  DW  sign-extended immediate
- id_ctrl  in  CTRL_W  remaining control bits
- read_reg1, read_reg2  out  AW  register file read addresses (= id_rs, id_rt)
- read_data1, read_data2  in  DW  register file read values
- wb_en, wb_reg, wb_value  in  1/AW/DW  writeback port, same signals sent to the register file
- flush  in  1  squash the instruction entering EX
- ex_ready  in  1  EX accepts a new instruction this cycle
- id_stall  out  1  IF/ID must hold its contents
- ex_valid, ex_mem_read, ex_reg_write  out  1  registered
- ex_rs_val, ex_rt_val, ex_imm  out  DW  registered
- ex_rs, ex_rt, ex_dst  out  AW  registered; ex_dst = id_rd
- ex_ctrl  out  CTRL_W  registered
- stall_count  out  16  saturating count of load-use bubbles

## Operation
- Combinational hazard: ex_valid & ex_mem_read & ex_dst≠0 & id_valid & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
- id_stall = hazard | ~ex_ready.
- Register update on posedge, priority order:
  - flush: ex_valid, ex_mem_read, ex_reg_write ← 0. Flush wins over hazard and ~ex_ready.
  - ~ex_ready: all ID/EX fields hold.
  - hazard: bubble. ex_valid, ex_mem_read, ex_reg_write ← 0, ex_ctrl ← 0. stall_count increments, saturating at 16'hFFFF.
  - otherwise: load all id_* fields and the operand values; ex_valid ← id_valid.
- Operand values: read_data1/read_data2, or the bypass value when enabled (see Configuration).
- Index 0 is never bypassed and never triggers a hazard. Operand for index 0 is whatever the register file returns, which is 0.
- A bubble clears ex_valid, so a hazard lasts exactly one cycle for a given load/consumer pair. A second consecutive load-use pair stalls again.

## Timing
- Latency is one cycle: id_* sampled at edge N appear on ex_* after edge N.
- id_stall and read_reg1/2 are combinational in the same cycle. There is no registered path from id_* to id_stall.
- Reset (rst=0): every registered output and stall_count go to 0 immediately, independent of clk. This includes ex_valid, ex_ctrl, ex_rs_val, ex_rt_val, ex_imm and all index outputs.
- Reset mid-stall: the pending instruction is lost. The first edge after release loads normally.
- Simultaneous hazard and ~ex_ready: hold wins. No bubble is inserted and stall_count is unchanged.

## Configuration
- ID_WB_BYPASS_EN defined: each operand takes wb_value when wb_en & wb_reg≠0 & wb_reg==index. This makes decode independent of register file write timing.
- ID_WB_BYPASS_EN undefined: operands come straight from read_data1/read_data2. Correctness relies on the register file completing its write before the posedge that captures ID/EX. wb_en, wb_reg and wb_value are ignored.

## Structure
- Shared package `cpu_pkg`: DW/AW defaults, the ex control bundle typedef (struct of mem_read, reg_write, ctrl), and the REG_ZERO constant.
- One sub-module, `load_use_detect`: purely combinational hazard compare, reused by the later forwarding unit.
- Pipeline register, bypass muxes and counter live in id_ex_stage.

## Test plan
- Reset: drive rst=0 with ex_* non-zero, async between edges -> all ex_* and stall_count read 0 before the next posedge.
- Plain advance: id_rs=3 (data 0x11), id_rt=4 (data 0x22), id_rd=5, id_valid=1 -> after one edge ex_rs_val=0x11, ex_rt_val=0x22, ex_dst=5, ex_valid=1, id_stall=0.
- Load-use: EX holds a load with ex_dst=7; ID has id_rs=7 -> id_stall=1 for one cycle, next ex_valid=0 and stall_count=1; the edge after that loads the consumer.
- Hazard suppression: ex_dst=0 load with id_rs=0, or id_uses_rt=0 with id_rt=ex_dst -> no stall.
- Flush and back-pressure: flush=1 with ex_ready=0 -> ex_valid=0. With ex_ready=0 for 3 cycles -> ex_* are stable and id_stall=1 throughout.
- Bypass (macro on): wb_en=1, wb_reg=9, wb_value=0xDEADBEEF, id_rs=9, read_data1=0 -> ex_rs_val=0xDEADBEEF. With wb_reg=0 -> ex_rs_val=read_data1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, the EX control bundle
// layout and the hard-wired zero register index.
package cpu_pkg;

   localparam int DW_DEF     = 32;
   localparam int AW_DEF     = 5;
   localparam int CTRL_W_DEF = 12;

   // Register index 0 always reads as zero and is never a real destination.
   localparam int REG_ZERO = 0;

   // Control carried alongside an instruction into EX.
   typedef struct packed {
      logic                  mem_read;
      logic                  reg_write;
      logic [CTRL_W_DEF-1:0] ctrl;
   } ex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in EX and the one in ID.
// Purely combinational so the forwarding unit can reuse it.
module load_use_detect
   import cpu_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          ex_valid,
   input  logic          ex_mem_read,
   input  logic [AW-1:0] ex_dst,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_uses_rt,
   output logic          hazard
);

   // A load in EX whose destination is a source of the ID instruction.
   always_comb begin
      hazard = ex_valid & ex_mem_read & (ex_dst != AW'(REG_ZERO)) & id_valid &
               ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register file addressing, optional writeback bypass,
// load-use bubble insertion, flush and EX back-pressure handling.
// Optional feature macro: ID_WB_BYPASS_EN (same-cycle writeback bypass).
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [AW-1:0]     id_rd,
   input  logic              id_uses_rt,
   input  logic              id_mem_read,
   input  logic              id_reg_write,
   input  logic [DW-1:0]     id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [AW-1:0]     read_reg1,
   output logic [AW-1:0]     read_reg2,
   input  logic [DW-1:0]     read_data1,
   input  logic [DW-1:0]     read_data2,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_reg,
   input  logic [DW-1:0]     wb_value,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              id_stall,
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic              ex_reg_write,
   output logic [DW-1:0]     ex_rs_val,
   output logic [DW-1:0]     ex_rt_val,
   output logic [DW-1:0]     ex_imm,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [AW-1:0]     ex_dst,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [15:0]       stall_count
);

   logic              valid_q, valid_d;
   logic              mem_read_q, mem_read_d;
   logic              reg_write_q, reg_write_d;
   logic [DW-1:0]     rs_val_q, rs_val_d;
   logic [DW-1:0]     rt_val_q, rt_val_d;
   logic [DW-1:0]     imm_q, imm_d;
   logic [AW-1:0]     rs_q, rs_d;
   logic [AW-1:0]     rt_q, rt_d;
   logic [AW-1:0]     dst_q, dst_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [15:0]       stall_count_q, stall_count_d;

   logic              hazard;
   logic [DW-1:0]     op1, op2;

   assign read_reg1 = id_rs;
   assign read_reg2 = id_rt;

   load_use_detect #(.AW(AW)) u_load_use_detect (
      .ex_valid   (valid_q),
      .ex_mem_read(mem_read_q),
      .ex_dst     (dst_q),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .hazard     (hazard)
   );

   assign id_stall = hazard | ~ex_ready;

`ifdef ID_WB_BYPASS_EN
   // Take the value being written back this cycle instead of the stale read.
   always_comb begin
      op1 = read_data1;
      op2 = read_data2;
      if (wb_en && (wb_reg != AW'(REG_ZERO)) && (wb_reg == id_rs)) op1 = wb_value;
      if (wb_en && (wb_reg != AW'(REG_ZERO)) && (wb_reg == id_rt)) op2 = wb_value;
   end
`else
   // Register file is trusted to finish its write before the capturing edge.
   assign op1 = read_data1;
   assign op2 = read_data2;
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_reg, wb_value};
`endif

   // Next ID/EX contents: flush > hold on back-pressure > bubble > advance.
   always_comb begin
      valid_d       = valid_q;
      mem_read_d    = mem_read_q;
      reg_write_d   = reg_write_q;
      rs_val_d      = rs_val_q;
      rt_val_d      = rt_val_q;
      imm_d         = imm_q;
      rs_d          = rs_q;
      rt_d          = rt_q;
      dst_d         = dst_q;
      ctrl_d        = ctrl_q;
      stall_count_d = stall_count_q;
      if (flush) begin
         valid_d     = 1'b0;
         mem_read_d  = 1'b0;
         reg_write_d = 1'b0;
      end else if (!ex_ready) begin
         // everything holds
      end else if (hazard) begin
         valid_d     = 1'b0;
         mem_read_d  = 1'b0;
         reg_write_d = 1'b0;
         ctrl_d      = '0;
         if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
      end else begin
         valid_d     = id_valid;
         mem_read_d  = id_mem_read;
         reg_write_d = id_reg_write;
         rs_val_d    = op1;
         rt_val_d    = op2;
         imm_d       = id_imm;
         rs_d        = id_rs;
         rt_d        = id_rt;
         dst_d       = id_rd;
         ctrl_d      = id_ctrl;
      end
   end

   // ID/EX register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q       <= 1'b0;
         mem_read_q    <= 1'b0;
         reg_write_q   <= 1'b0;
         rs_val_q      <= '0;
         rt_val_q      <= '0;
         imm_q         <= '0;
         rs_q          <= '0;
         rt_q          <= '0;
         dst_q         <= '0;
         ctrl_q        <= '0;
         stall_count_q <= '0;
      end else begin
         valid_q       <= valid_d;
         mem_read_q    <= mem_read_d;
         reg_write_q   <= reg_write_d;
         rs_val_q      <= rs_val_d;
         rt_val_q      <= rt_val_d;
         imm_q         <= imm_d;
         rs_q          <= rs_d;
         rt_q          <= rt_d;
         dst_q         <= dst_d;
         ctrl_q        <= ctrl_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_mem_read  = mem_read_q;
   assign ex_reg_write = reg_write_q;
   assign ex_rs_val    = rs_val_q;
   assign ex_rt_val    = rt_val_q;
   assign ex_imm       = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_dst       = dst_q;
   assign ex_ctrl      = ctrl_q;
   assign stall_count  = stall_count_q;

endmodule
